// File: rtl/mapa_pkg.sv
// Shared map-cell and fruit-generator state encodings, imported by the
// fruit generator and by the map update logic.
package mapa_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    CELL_FREE     = 2'b00,
    CELL_SNAKE    = 2'b01,
    CELL_FRUIT    = 2'b10,
    CELL_OBSTACLE = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SORTEIA = 3'd1,
    S_LE      = 3'd2,
    S_ESPERA  = 3'd3,
    S_CHECA   = 3'd4,
    S_VARRE   = 3'd5,
    S_PRONTO  = 3'd6
  } fruta_state_t;

  // An old fruit counts as occupied, so only CELL_FREE accepts a new one.
  function automatic logic cell_free(input cell_t c);
    return (c == CELL_FREE);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), one step per cycle.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_value
);

  logic [15:0] r_value;
  logic        w_feedback;

  assign w_feedback = r_value[15] ^ r_value[13] ^ r_value[12] ^ r_value[10];

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_value <= SEED;
    else        r_value <= {r_value[14:0], w_feedback};
  end

  assign o_value = r_value;

endmodule

// File: rtl/fruta_gen.sv
// Fruit position generator: random candidates by rejection sampling, then a
// linear map scan after MAX_TRIES misses; reports full when no cell is free.
module fruta_gen
  import mapa_pkg::*;
#(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter int          MAX_TRIES   = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fruta_enable,
  output logic               fruta_wenable,
  output logic [COORD_W-1:0] fruta_wx,
  output logic [COORD_W-1:0] fruta_wy,
  output logic               fruta_full,
  output logic               fruta_renable,
  output logic [COORD_W-1:0] fruta_rx,
  output logic [COORD_W-1:0] fruta_ry,
  input  logic [1:0]         fruta_rdata
);

  localparam int CELLS = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int CNT_W = $clog2(CELLS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(MAPA_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(MAPA_HEIGHT - 1);
  localparam logic [COORD_W-1:0] RESET_XY  = COORD_W'(13);
  localparam logic [CNT_W-1:0]   LAST_CELL = CNT_W'(CELLS - 1);
  localparam logic [TRY_W-1:0]   TRY_LIMIT = TRY_W'(MAX_TRIES);

  fruta_state_t       r_state, w_next;
  logic [COORD_W-1:0] r_cx, r_cy, r_wx, r_wy;
  logic [TRY_W-1:0]   r_tries;
  logic [CNT_W-1:0]   r_scanned;
  logic               r_scan, r_full;
  cell_t              r_cell;

  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr;
  logic [COORD_W-1:0] w_rand_x, w_rand_y, w_step_x, w_step_y;
  logic [TRY_W-1:0]   w_tries_inc;
  logic               w_cand_ok, w_free, w_tries_last, w_scan_last;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .o_value (w_lfsr)
  );

  assign w_unused_lfsr = ^{w_lfsr[15:13], w_lfsr[7:6]};
  assign w_rand_x      = COORD_W'(w_lfsr[5:0]);
  assign w_rand_y      = COORD_W'(w_lfsr[12:8]);
  assign w_cand_ok     = (w_rand_x <= LAST_X) && (w_rand_y <= LAST_Y);

  // Raster step used by the scan: wrap x into the next row, y back to the top.
  assign w_step_x = (r_cx == LAST_X) ? '0 : r_cx + 1'b1;
  assign w_step_y = (r_cx != LAST_X) ? r_cy : ((r_cy == LAST_Y) ? '0 : r_cy + 1'b1);

  assign w_free       = cell_free(r_cell);
  assign w_tries_inc  = r_tries + 1'b1;
  assign w_tries_last = (w_tries_inc == TRY_LIMIT);
  assign w_scan_last  = (r_scanned == LAST_CELL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case, so every path assigns it
  // and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (fruta_enable) w_next = S_SORTEIA;
      S_SORTEIA: if (w_cand_ok) w_next = S_LE;
      S_LE:      w_next = S_ESPERA;
      S_VARRE:   w_next = S_ESPERA;
      S_ESPERA:  w_next = S_CHECA;
      S_CHECA: begin
        if (w_free)            w_next = S_PRONTO;
        else if (r_scan)       w_next = w_scan_last ? S_PRONTO : S_VARRE;
        else if (w_tries_last) w_next = S_VARRE;
        else                   w_next = S_SORTEIA;
      end
      S_PRONTO:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx      <= '0;
      r_cy      <= '0;
      r_wx      <= RESET_XY;
      r_wy      <= RESET_XY;
      r_tries   <= '0;
      r_scanned <= '0;
      r_scan    <= 1'b0;
      r_full    <= 1'b0;
      r_cell    <= CELL_FREE;
    end else begin
      case (r_state)
        S_IDLE: if (fruta_enable) begin
          r_tries   <= '0;
          r_scanned <= '0;
          r_scan    <= 1'b0;
          r_full    <= 1'b0;
        end
        S_SORTEIA: if (w_cand_ok) begin
          r_cx <= w_rand_x;
          r_cy <= w_rand_y;
        end
        S_ESPERA: r_cell <= cell_t'(fruta_rdata);
        S_CHECA: begin
          if (w_next == S_PRONTO) begin
            r_wx   <= r_cx;
            r_wy   <= r_cy;
            r_full <= !w_free;
          end else if (w_next == S_VARRE) begin
            r_cx <= w_step_x;
            r_cy <= w_step_y;
            if (r_scan) begin
              r_scanned <= r_scanned + 1'b1;
            end else begin
              r_tries   <= w_tries_inc;
              r_scan    <= 1'b1;
              r_scanned <= '0;
            end
          end else begin
            r_tries <= w_tries_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign fruta_renable = (r_state == S_LE) || (r_state == S_VARRE);
  assign fruta_rx      = r_cx;
  assign fruta_ry      = r_cy;
  assign fruta_wenable = (r_state == S_PRONTO);
  assign fruta_full    = fruta_wenable && r_full;
  assign fruta_wx      = r_wx;
  assign fruta_wy      = r_wy;

endmodule

// File: tb/tb_fruta_gen.sv
// Self-checking bench for fruta_gen: map RAM model, spec-level LFSR and search
// model, table-driven map scenarios, reset/re-request sequences, random maps.
module tb_fruta_gen;
  import mapa_pkg::*;

  localparam int          W          = 40;
  localparam int          H          = 30;
  localparam int          MAXT       = 16;
  localparam int          CELLS      = W * H;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          REQ_BUDGET = 6000;
  localparam int          N_RANDOM   = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fruta_enable = 1'b0;
  logic       fruta_wenable, fruta_full, fruta_renable;
  logic [9:0] fruta_wx, fruta_wy, fruta_rx, fruta_ry;
  logic [1:0] fruta_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int wen_pulses = 0;
  int proto_viol = 0;

  logic [1:0]  map_mem [H][W];
  logic [1:0]  rd_q = 2'b00;
  logic [15:0] m_lfsr;
  logic        prev_ren = 1'b0;

  fruta_gen #(
    .MAPA_WIDTH (W),
    .MAPA_HEIGHT(H),
    .MAX_TRIES  (MAXT),
    .SEED       (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fruta_enable (fruta_enable),
    .fruta_wenable(fruta_wenable),
    .fruta_wx     (fruta_wx),
    .fruta_wy     (fruta_wy),
    .fruta_full   (fruta_full),
    .fruta_renable(fruta_renable),
    .fruta_rx     (fruta_rx),
    .fruta_ry     (fruta_ry),
    .fruta_rdata  (fruta_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous map RAM: data appears the cycle after the read strobe and holds.
  always @(posedge clk)
    if (fruta_renable && fruta_rx < 10'(W) && fruta_ry < 10'(H))
      rd_q <= map_mem[fruta_ry][fruta_rx];
  assign fruta_rdata = rd_q;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);

  // Read-port protocol watch and write-pulse counter.
  always @(negedge clk) begin
    if (reset && fruta_renable) begin
      if (fruta_rx >= 10'(W) || fruta_ry >= 10'(H)) proto_viol <= proto_viol + 1;
      if (prev_ren) proto_viol <= proto_viol + 1;
    end
    if (fruta_wenable) wen_pulses <= wen_pulses + 1;
    prev_ren <= fruta_renable;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_map(input logic [1:0] fill, input int fx, input int fy);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        map_mem[y][x] = fill;
    if (fx >= 0) map_mem[fy][fx] = 2'b00;
  endtask

  // Search model from the rules: cycle 1 is the first draw cycle; each accepted
  // draw costs draw+read+wait+check, each scanned cell costs 3 cycles.
  task automatic predict(input logic [15:0] l0, output int ex, output int ey,
                         output int efull, output int elat);
    logic [15:0] l;
    int t, tries, x, y;
    l = l0; t = 1; tries = 0; x = 0; y = 0;
    ex = 0; ey = 0; efull = 0; elat = 0;
    while (tries < MAXT) begin
      x = int'(l[5:0]);
      y = int'(l[12:8]);
      if (x >= W || y >= H) begin
        l = lfsr_next(l);
        t++;
      end else if (map_mem[y][x] == 2'b00) begin
        ex = x; ey = y; elat = t + 4;
        return;
      end else begin
        tries++;
        for (int k = 0; k < 4; k++) l = lfsr_next(l);
        t += 4;
      end
    end
    for (int k = 1; k <= CELLS; k++) begin
      x++;
      if (x == W) begin
        x = 0;
        y = (y == H - 1) ? 0 : y + 1;
      end
      if (map_mem[y][x] == 2'b00) begin
        ex = x; ey = y; elat = t + 3 * k;
        return;
      end
    end
    ex = x; ey = y; efull = 1; elat = t + 3 * CELLS;
  endtask

  task automatic do_request(input string tag, input bit extra_en,
                            output int gx, output int gy, output int gfull);
    logic [15:0] l0;
    int ex, ey, efull, elat, glat, pulses0;
    bit found;
    gx = 0; gy = 0; gfull = 0; glat = 0; found = 1'b0;
    pulses0 = wen_pulses;
    @(negedge clk); fruta_enable = 1'b1;
    @(negedge clk); fruta_enable = 1'b0;
    l0 = m_lfsr;
    predict(l0, ex, ey, efull, elat);
    for (int c = 1; c <= REQ_BUDGET; c++) begin
      if (fruta_wenable) begin
        found = 1'b1; glat = c;
        gx = int'(fruta_wx); gy = int'(fruta_wy); gfull = int'(fruta_full);
        break;
      end
      fruta_enable = extra_en && (c == 1 || c == 2);
      @(negedge clk);
    end
    fruta_enable = 1'b0;
    check({tag, " completed within budget"}, int'(found), 1);
    if (found) begin
      check({tag, " latency"}, glat, elat);
      check({tag, " wx"}, gx, ex);
      check({tag, " wy"}, gy, ey);
      check({tag, " full"}, gfull, efull);
      if (gfull == 0 && gx < W && gy < H)
        check({tag, " chosen cell free"}, int'(map_mem[gy][gx]), 0);
      @(negedge clk);
      check({tag, " wenable single cycle"}, int'(fruta_wenable), 0);
      check({tag, " wx held"}, int'(fruta_wx), gx);
      repeat (7) @(negedge clk);
      check({tag, " one pulse per request"}, wen_pulses - pulses0, 1);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] fill;
    int         free_x;
    int         free_y;
    int         exp_full;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int gx, gy, gf, pulses0, d;

    vecs[0] = '{"only (39,29) free, snake", 2'b01, 39, 29, 0};
    vecs[1] = '{"only (0,0) free, old fruit", 2'b10, 0, 0, 0};
    vecs[2] = '{"only (39,0) free, obstacle", 2'b11, 39, 0, 0};
    vecs[3] = '{"map full of obstacles", 2'b11, -1, -1, 1};
    vecs[4] = '{"only (0,29) free, snake", 2'b01, 0, 29, 0};

    fill_map(2'b00, -1, -1);
    repeat (3) @(negedge clk);
    check("reset wx", int'(fruta_wx), 13);
    check("reset wy", int'(fruta_wy), 13);
    check("reset wenable", int'(fruta_wenable), 0);
    check("reset full", int'(fruta_full), 0);
    check("reset renable", int'(fruta_renable), 0);
    check("reset rx/ry", int'({fruta_rx, fruta_ry}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_request("empty map", 1'b0, gx, gy, gf);
    do_request("extra enables ignored", 1'b1, gx, gy, gf);

    for (int i = 0; i < 5; i++) begin
      fill_map(vecs[i].fill, vecs[i].free_x, vecs[i].free_y);
      do_request(vecs[i].name, 1'b0, gx, gy, gf);
      check({vecs[i].name, " table full"}, gf, vecs[i].exp_full);
      if (vecs[i].exp_full == 0) begin
        check({vecs[i].name, " table x"}, gx, vecs[i].free_x);
        check({vecs[i].name, " table y"}, gy, vecs[i].free_y);
      end
    end

    // Abort a search with reset two cycles after the request.
    fill_map(2'b00, -1, -1);
    pulses0 = wen_pulses;
    @(negedge clk); fruta_enable = 1'b1;
    @(negedge clk); fruta_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort wx reset value", int'(fruta_wx), 13);
    check("abort wy reset value", int'(fruta_wy), 13);
    check("abort strobes low", int'({fruta_wenable, fruta_full, fruta_renable}), 0);
    check("abort rx/ry zero", int'({fruta_rx, fruta_ry}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort no write pulse", wen_pulses - pulses0, 0);
    do_request("request after abort", 1'b0, gx, gy, gf);

    for (int n = 0; n < N_RANDOM; n++) begin
      d = $urandom_range(95, 0);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          map_mem[y][x] = ($urandom_range(99, 0) < d) ? 2'($urandom_range(3, 1)) : 2'b00;
      repeat ($urandom_range(3, 0)) @(negedge clk);
      do_request($sformatf("random map %0d density %0d", n, d), 1'($urandom_range(1, 0)),
                 gx, gy, gf);
    end

    check("read-port protocol violations", proto_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
